// File: rtl/press_classifier_if.sv
// Button-side bundle for press_classifier: raw button levels in, debounced
// levels and one-cycle short/long press events out.
interface press_classifier_if;
  logic btn_r;
  logic btn_l;
  logic button_r_s;
  logic button_r_l;
  logic button_l_s;
  logic button_l_l;
  logic btn_r_db;
  logic btn_l_db;

  modport master (
    output btn_r,
    output btn_l,
    input  button_r_s,
    input  button_r_l,
    input  button_l_s,
    input  button_l_l,
    input  btn_r_db,
    input  btn_l_db
  );

  modport slave (
    input  btn_r,
    input  btn_l,
    output button_r_s,
    output button_r_l,
    output button_l_s,
    output button_l_l,
    output btn_r_db,
    output btn_l_db
  );
endinterface

// File: rtl/press_classifier.sv
// Two independent button channels: 2-FF sync, debounce, short/long press FSM.
// Optional auto-repeat of short pulses while held long: define PRESS_REPEAT_EN.
module press_classifier #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic               clk,
  input  logic               rst_n,
  press_classifier_if.slave  bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  // Compared before the increment, so the hit lands as the count reaches LONG_CYCLES-1.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};

`ifdef PRESS_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("press_classifier: illegal DEBOUNCE/LONG/REPEAT parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_e;

  // Channel 0 is the right button, channel 1 the left.
  logic [1:0] raw_s;
  logic [1:0] db_lvl_s;
  logic [1:0] short_s;
  logic [1:0] long_s;

  assign raw_s = {bus.btn_l, bus.btn_r};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            db_q, db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    state_e              state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                short_q;
    logic                long_q;
`ifdef PRESS_REPEAT_EN
    logic [REP_W-1:0]    rep_q;
`endif

    // Next-state for synchronizer and debouncer.
    always_comb begin
      sync1_d  = raw_s[c];
      sync2_d  = sync1_q;
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      if (sync2_q == db_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_d     = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Synchronizer and debouncer registers.
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        db_q     <= 1'b0;
        db_cnt_q <= '0;
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        db_q     <= db_d;
        db_cnt_q <= db_cnt_d;
      end
    end

    // Press classifier FSM with registered event pulses.
    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
`ifdef PRESS_REPEAT_EN
        rep_q   <= '0;
`endif
      end else begin
        short_q <= 1'b0;
        long_q  <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (db_q) begin
              hold_q  <= '0;
              state_q <= ST_PRESSED;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (!db_q) begin
              short_q <= 1'b1;
              state_q <= ST_IDLE;
            end else if (hold_q == HOLD_LAST) begin
              long_q  <= 1'b1;
              hold_q  <= hold_q + HOLD_W'(1);
              state_q <= ST_LONG;
`ifdef PRESS_REPEAT_EN
              rep_q   <= '0;
`endif
            end else if (hold_q != HOLD_MAX) begin
              hold_q  <= hold_q + HOLD_W'(1);
            end else begin
              hold_q  <= hold_q;
            end
          end
          ST_LONG: begin
            if (!db_q) begin
              state_q <= ST_IDLE;
`ifdef PRESS_REPEAT_EN
              rep_q   <= '0;
            end else if (rep_q == REP_LAST) begin
              // Held long: re-emit a short pulse every REPEAT_CYCLES.
              short_q <= 1'b1;
              rep_q   <= '0;
            end else begin
              rep_q   <= rep_q + REP_W'(1);
`else
            end else begin
              state_q <= ST_LONG;
`endif
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end

    assign db_lvl_s[c] = db_q;
    assign short_s[c]  = short_q;
    assign long_s[c]   = long_q;
  end

  assign bus.btn_r_db   = db_lvl_s[0];
  assign bus.btn_l_db   = db_lvl_s[1];
  assign bus.button_r_s = short_s[0];
  assign bus.button_r_l = long_s[0];
  assign bus.button_l_s = short_s[1];
  assign bus.button_l_l = long_s[1];

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier (DEBOUNCE=4, LONG=20, REPEAT=8):
// directed vector table, hand-written corner sequences and random stimulus
// compared each cycle against a window/duration based reference model.
module tb_press_classifier;
  localparam int D    = 4;
  localparam int L    = 20;
  localparam int R    = 8;
  localparam int NVEC = 6;

  logic clk;
  logic rst_n;

  press_classifier_if bus ();

  press_classifier #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: db flips once the last D synchronized samples all
  // disagree with it; events follow from how long db has been high.
  bit m_pipe [2][2];
  bit m_hist [2][D];
  bit m_db   [2];
  int m_hi_len [2];
  int m_ended  [2];
  bit m_s [2];
  bit m_l [2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pipe[c][0] = 1'b0;
      m_pipe[c][1] = 1'b0;
      for (int k = 0; k < D; k++) m_hist[c][k] = 1'b0;
      m_db[c]     = 1'b0;
      m_hi_len[c] = 0;
      m_ended[c]  = 0;
      m_s[c]      = 1'b0;
      m_l[c]      = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit raw_r, input bit raw_l);
    bit raw [2];
    bit seen;
    bit prev;
    bit flip;
    raw[0] = raw_r;
    raw[1] = raw_l;
    for (int c = 0; c < 2; c++) begin
      seen = m_pipe[c][1];
      m_pipe[c][1] = m_pipe[c][0];
      m_pipe[c][0] = raw[c];
      prev = m_db[c];
      m_s[c] = 1'b0;
      m_l[c] = 1'b0;
      if (prev) begin
        if (m_hi_len[c] == L) m_l[c] = 1'b1;
`ifdef PRESS_REPEAT_EN
        else if (m_hi_len[c] > L && ((m_hi_len[c] - L) % R) == 0) m_s[c] = 1'b1;
`endif
      end else if (m_ended[c] > 0 && m_ended[c] < L) begin
        m_s[c] = 1'b1;
      end
      m_ended[c] = 0;
      for (int k = D - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = seen;
      flip = 1'b1;
      for (int k = 0; k < D; k++) if (m_hist[c][k] == prev) flip = 1'b0;
      if (flip) m_db[c] = !prev;
      if (m_db[c]) begin
        m_hi_len[c] = m_hi_len[c] + 1;
      end else if (prev) begin
        m_ended[c]  = m_hi_len[c];
        m_hi_len[c] = 0;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_reset();
    else model_edge(bus.btn_r, bus.btn_l);
    #1;
    check("model_r_db", bus.btn_r_db,   m_db[0]);
    check("model_l_db", bus.btn_l_db,   m_db[1]);
    check("model_r_s",  bus.button_r_s, m_s[0]);
    check("model_r_l",  bus.button_r_l, m_l[0]);
    check("model_l_s",  bus.button_l_s, m_s[1]);
    check("model_l_l",  bus.button_l_l, m_l[1]);
  endtask

  function automatic int pick_len();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       return $urandom_range(1, 3);
      1:       return $urandom_range(4, 12);
      2:       return $urandom_range(15, 25);
      default: return $urandom_range(26, 60);
    endcase
  endfunction

  // Right-channel clean press of 'hold' raw cycles; edges counted from the
  // first sampling edge of the press (0 = never).
  typedef struct {
    int hold;
    int rise;
    int fall;
    int lng;
    int short1;
    int nshort;
  } vec_t;

  vec_t vecs [NVEC];

  initial begin
    int rise, fall, lng, s1, ns, nl, rs, ls, db_hi, lp, lvl, w, e;
    int run_r, run_l;
    bit lvl_r, lvl_l;

    vecs[0] = '{10, 6, 16,  0, 17, 1};
    vecs[1] = '{ 4, 6, 10,  0, 11, 1};
    vecs[2] = '{ 3, 0,  0,  0,  0, 0};
    vecs[3] = '{19, 6, 25,  0, 26, 1};
    vecs[4] = '{20, 6, 26, 26,  0, 0};
`ifdef PRESS_REPEAT_EN
    vecs[5] = '{40, 6, 46, 26, 34, 2};
`else
    vecs[5] = '{40, 6, 46, 26,  0, 0};
`endif

    bus.btn_r = 1'b0;
    bus.btn_l = 1'b0;
    rst_n     = 1'b1;
    model_reset();
    #1;
    check("reset_r_db", bus.btn_r_db,   0);
    check("reset_l_db", bus.btn_l_db,   0);
    check("reset_r_s",  bus.button_r_s, 0);
    check("reset_r_l",  bus.button_r_l, 0);
    check("reset_l_s",  bus.button_l_s, 0);
    check("reset_l_l",  bus.button_l_l, 0);
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) step();

    for (int i = 0; i < NVEC; i++) begin
      rise = 0; fall = 0; lng = 0; s1 = 0; ns = 0; nl = 0;
      bus.btn_r = 1'b1;
      for (int k = 1; k <= 70; k++) begin
        step();
        if (bus.btn_r_db === 1'b1 && rise == 0) rise = k;
        if (bus.btn_r_db === 1'b0 && rise != 0 && fall == 0) fall = k;
        if (bus.button_r_l === 1'b1) begin nl++; if (lng == 0) lng = k; end
        if (bus.button_r_s === 1'b1) begin ns++; if (s1 == 0) s1 = k; end
        if (k == vecs[i].hold) bus.btn_r = 1'b0;
      end
      check($sformatf("vec%0d_db_rise", i),    rise, vecs[i].rise);
      check($sformatf("vec%0d_db_fall", i),    fall, vecs[i].fall);
      check($sformatf("vec%0d_long_edge", i),  lng,  vecs[i].lng);
      check($sformatf("vec%0d_long_count", i), nl,   (vecs[i].lng != 0) ? 1 : 0);
      check($sformatf("vec%0d_short_edge", i), s1,   vecs[i].short1);
      check($sformatf("vec%0d_short_count", i), ns,  vecs[i].nshort);
    end

    // Simultaneous 10-cycle presses on both channels.
    rs = 0; ls = 0; nl = 0;
    bus.btn_r = 1'b1;
    bus.btn_l = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (bus.button_r_s === 1'b1 && rs == 0) rs = k;
      if (bus.button_l_s === 1'b1 && ls == 0) ls = k;
      if (bus.button_r_l === 1'b1 || bus.button_l_l === 1'b1) nl++;
      if (k == 10) begin bus.btn_r = 1'b0; bus.btn_l = 1'b0; end
    end
    check("sim_r_short_edge", rs, 17);
    check("sim_l_short_edge", ls, 17);
    check("sim_no_long", nl, 0);

    // Bounce on the left: pulses 1..3 cycles wide never debounce.
    db_hi = 0; lp = 0; lvl = 1; e = 0;
    while (e < 30) begin
      w = $urandom_range(1, 3);
      bus.btn_l = lvl[0];
      for (int k = 0; k < w; k++) begin
        step();
        if (bus.btn_l_db !== 1'b0) db_hi++;
        if (bus.button_l_s !== 1'b0 || bus.button_l_l !== 1'b0) lp++;
      end
      e   = e + w;
      lvl = 1 - lvl;
    end
    bus.btn_l = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.btn_l_db !== 1'b0) db_hi++;
      if (bus.button_l_s !== 1'b0 || bus.button_l_l !== 1'b0) lp++;
    end
    check("bounce_db_high_cycles", db_hi, 0);
    check("bounce_left_pulses", lp, 0);

    // Reset 15 cycles into a left press that stays held afterwards.
    ns = 0; lng = 0;
    bus.btn_l = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (bus.button_l_s === 1'b1) ns++;
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_mid_l_db", bus.btn_l_db,   0);
    check("rst_mid_r_db", bus.btn_r_db,   0);
    check("rst_mid_l_s",  bus.button_l_s, 0);
    check("rst_mid_l_l",  bus.button_l_l, 0);
    check("rst_mid_r_s",  bus.button_r_s, 0);
    check("rst_mid_r_l",  bus.button_r_l, 0);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.button_l_s === 1'b1) ns++;
      if (bus.button_l_l === 1'b1 && lng == 0) lng = k;
      if (k == 26) bus.btn_l = 1'b0;
    end
    check("rst_no_short", ns, 0);
    check("rst_held_long_edge", lng, 26);

    // Random independent activity on both channels.
    lvl_r = 1'b0; lvl_l = 1'b0;
    run_r = pick_len(); run_l = pick_len();
    for (int k = 0; k < 3000; k++) begin
      if (run_r == 0) begin lvl_r = !lvl_r; run_r = pick_len(); end
      if (run_l == 0) begin lvl_l = !lvl_l; run_l = pick_len(); end
      bus.btn_r = lvl_r;
      bus.btn_l = lvl_l;
      step();
      run_r--;
      run_l--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
